// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use, data-memory-wait and halt handling.
//
// Ports
//   CLK, nRST                : clock, async active-low reset
//   ihit, dhit               : imem / dmem completion strobes
//   exmem_memreq             : EX/MEM holds an outstanding dmem access
//   flush                    : branch/jump taken, squash decode instruction
//   *_id                     : decode-stage instruction word, operands, control
//   *_ex                     : registered EX-stage copies of the *_id inputs
//   valid_ex                 : EX holds a real instruction (0 = bubble)
//   stall_ifid               : combinational, hold PC and IF/ID this cycle
//   halted                   : registered, a halt has reached EX
//   stall_cnt                : saturating count of stall cycles while running
//
// state  | meaning
// RUN    | normal pipelined operation
// HALTED | halt reached EX; every advance loads a bubble until reset
module idex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_memreq,
  input  logic             flush,
  input  logic [31:0]      imemload_id,
  input  logic [31:0]      pc4_id,
  input  logic [31:0]      imm_id,
  input  logic [31:0]      rdat1_id,
  input  logic [31:0]      rdat2_id,
  input  logic             wen_id,
  input  logic             dren_id,
  input  logic             dwen_id,
  input  logic             halt_id,
  input  logic [4:0]       wsel_id,
  input  logic [3:0]       aluop_id,
  output logic [31:0]      imemload_ex,
  output logic [31:0]      pc4_ex,
  output logic [31:0]      imm_ex,
  output logic [31:0]      rdat1_ex,
  output logic [31:0]      rdat2_ex,
  output logic             wen_ex,
  output logic             dren_ex,
  output logic             dwen_ex,
  output logic             halt_ex,
  output logic [4:0]       wsel_ex,
  output logic [3:0]       aluop_ex,
  output logic             valid_ex,
  output logic             stall_ifid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t     state;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       busy;
  logic       advance;
  logic       lu_hazard;
  logic       bubble;

  assign rs_id   = imemload_id[25:21];
  assign rt_id   = imemload_id[20:16];
  assign busy    = exmem_memreq && !dhit;
  assign advance = ihit && !busy;

  // valid_ex gates the hazard so the bubble it inserts clears it on the next
  // advance and the held instruction loads without a second bubble.
  assign lu_hazard = valid_ex && dren_ex && (wsel_ex != 5'd0) &&
                     ((wsel_ex == rs_id) || (wsel_ex == rt_id));

  assign stall_ifid = busy || lu_hazard || !ihit || halted;
  assign bubble     = (state == HALTED) || flush || lu_hazard;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      halted      <= 1'b0;
      stall_cnt   <= '0;
      imemload_ex <= '0;
      pc4_ex      <= '0;
      imm_ex      <= '0;
      rdat1_ex    <= '0;
      rdat2_ex    <= '0;
      wen_ex      <= 1'b0;
      dren_ex     <= 1'b0;
      dwen_ex     <= 1'b0;
      halt_ex     <= 1'b0;
      wsel_ex     <= '0;
      aluop_ex    <= '0;
      valid_ex    <= 1'b0;
    end else begin
      if ((state == RUN) && stall_ifid && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (advance) begin
        if (bubble) begin
          imemload_ex <= '0;
          pc4_ex      <= '0;
          imm_ex      <= '0;
          rdat1_ex    <= '0;
          rdat2_ex    <= '0;
          wen_ex      <= 1'b0;
          dren_ex     <= 1'b0;
          dwen_ex     <= 1'b0;
          halt_ex     <= 1'b0;
          wsel_ex     <= '0;
          aluop_ex    <= '0;
          valid_ex    <= 1'b0;
        end else begin
          imemload_ex <= imemload_id;
          pc4_ex      <= pc4_id;
          imm_ex      <= imm_id;
          rdat1_ex    <= rdat1_id;
          rdat2_ex    <= rdat2_id;
          wen_ex      <= wen_id;
          dren_ex     <= dren_id;
          dwen_ex     <= dwen_id;
          halt_ex     <= halt_id;
          wsel_ex     <= wsel_id;
          aluop_ex    <= aluop_id;
          valid_ex    <= 1'b1;
          if (halt_id) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Directed-vector bench for idex_stage: a default-width instance plus a 4-bit
// counter instance on the same stimulus for the saturation case.
module tb_idex_stage;

  logic        CLK, nRST;
  logic        ihit, dhit, exmem_memreq, flush;
  logic [31:0] imemload_id, pc4_id, imm_id, rdat1_id, rdat2_id;
  logic        wen_id, dren_id, dwen_id, halt_id;
  logic [4:0]  wsel_id;
  logic [3:0]  aluop_id;

  logic [31:0] imemload_ex, pc4_ex, imm_ex, rdat1_ex, rdat2_ex;
  logic        wen_ex, dren_ex, dwen_ex, halt_ex, valid_ex, stall_ifid, halted;
  logic [4:0]  wsel_ex;
  logic [3:0]  aluop_ex;
  logic [15:0] stall_cnt;

  logic [31:0] q4_imemload_ex, q4_pc4_ex, q4_imm_ex, q4_rdat1_ex, q4_rdat2_ex;
  logic        q4_wen_ex, q4_dren_ex, q4_dwen_ex, q4_halt_ex, q4_valid_ex;
  logic        q4_stall_ifid, q4_halted;
  logic [4:0]  q4_wsel_ex;
  logic [3:0]  q4_aluop_ex;
  logic [3:0]  q4_stall_cnt;

  int checks = 0;
  int errors = 0;

  idex_stage #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_memreq(exmem_memreq), .flush(flush),
    .imemload_id(imemload_id), .pc4_id(pc4_id), .imm_id(imm_id),
    .rdat1_id(rdat1_id), .rdat2_id(rdat2_id), .wen_id(wen_id),
    .dren_id(dren_id), .dwen_id(dwen_id), .halt_id(halt_id),
    .wsel_id(wsel_id), .aluop_id(aluop_id),
    .imemload_ex(imemload_ex), .pc4_ex(pc4_ex), .imm_ex(imm_ex),
    .rdat1_ex(rdat1_ex), .rdat2_ex(rdat2_ex), .wen_ex(wen_ex),
    .dren_ex(dren_ex), .dwen_ex(dwen_ex), .halt_ex(halt_ex),
    .wsel_ex(wsel_ex), .aluop_ex(aluop_ex), .valid_ex(valid_ex),
    .stall_ifid(stall_ifid), .halted(halted), .stall_cnt(stall_cnt)
  );

  idex_stage #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_memreq(exmem_memreq), .flush(flush),
    .imemload_id(imemload_id), .pc4_id(pc4_id), .imm_id(imm_id),
    .rdat1_id(rdat1_id), .rdat2_id(rdat2_id), .wen_id(wen_id),
    .dren_id(dren_id), .dwen_id(dwen_id), .halt_id(halt_id),
    .wsel_id(wsel_id), .aluop_id(aluop_id),
    .imemload_ex(q4_imemload_ex), .pc4_ex(q4_pc4_ex), .imm_ex(q4_imm_ex),
    .rdat1_ex(q4_rdat1_ex), .rdat2_ex(q4_rdat2_ex), .wen_ex(q4_wen_ex),
    .dren_ex(q4_dren_ex), .dwen_ex(q4_dwen_ex), .halt_ex(q4_halt_ex),
    .wsel_ex(q4_wsel_ex), .aluop_ex(q4_aluop_ex), .valid_ex(q4_valid_ex),
    .stall_ifid(q4_stall_ifid), .halted(q4_halted), .stall_cnt(q4_stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] iw, input logic [4:0] ws, input logic w,
                           input logic dr, input logic dw, input logic h, input logic [31:0] r1);
    imemload_id = iw;
    wsel_id     = ws;
    wen_id      = w;
    dren_id     = dr;
    dwen_id     = dw;
    halt_id     = h;
    rdat1_id    = r1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; exmem_memreq = 1'b0; flush = 1'b0;
    imemload_id = '0; pc4_id = '0; imm_id = '0; rdat1_id = '0; rdat2_id = '0;
    wen_id = 1'b0; dren_id = 1'b0; dwen_id = 1'b0; halt_id = 1'b0;
    wsel_id = '0; aluop_id = '0;

    #3;
    check_val("rst_valid", valid_ex, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_cnt", stall_cnt, 0);
    check_val("rst_stall_noihit", stall_ifid, 1);

    // add $10,$8,$9
    ihit = 1'b1; pc4_id = 32'h104; imm_id = 32'h5020; rdat2_id = 32'd7; aluop_id = 4'h2;
    set_instr(32'h01095020, 5'd10, 1, 0, 0, 0, 32'd5);
    #9 nRST = 1'b1;
    #1 check_val("norm_stall_pre", stall_ifid, 0);
    step();
    check_val("norm_valid", valid_ex, 1);
    check_val("norm_rdat1", rdat1_ex, 5);
    check_val("norm_wsel", wsel_ex, 10);
    check_val("norm_imem", imemload_ex, 32'h01095020);
    check_val("norm_pc4", pc4_ex, 32'h104);
    check_val("norm_rdat2", rdat2_ex, 7);
    check_val("norm_aluop", aluop_ex, 2);
    check_val("norm_wen", wen_ex, 1);
    check_val("norm_cnt", stall_cnt, 0);

    // load-use: lw $8,0($4) then add $10,$8,$9
    set_instr(32'h8C880000, 5'd8, 1, 1, 0, 0, 32'd3);
    #1 check_val("lw_stall_pre", stall_ifid, 0);
    step();
    check_val("lw_dren", dren_ex, 1);
    check_val("lw_wsel", wsel_ex, 8);
    set_instr(32'h01095020, 5'd10, 1, 0, 0, 0, 32'd5);
    #1 check_val("lu_stall", stall_ifid, 1);
    step();
    check_val("lu_bubble_valid", valid_ex, 0);
    check_val("lu_bubble_wsel", wsel_ex, 0);
    check_val("lu_bubble_wen", wen_ex, 0);
    check_val("lu_bubble_rdat1", rdat1_ex, 0);
    check_val("lu_cnt", stall_cnt, 1);
    check_val("lu_stall_after", stall_ifid, 0);
    step();
    check_val("lu_held_valid", valid_ex, 1);
    check_val("lu_held_wsel", wsel_ex, 10);
    check_val("lu_held_rdat1", rdat1_ex, 5);
    check_val("lu_cnt2", stall_cnt, 1);

    // lw to $0 never creates a hazard
    set_instr(32'h8C800000, 5'd0, 1, 1, 0, 0, 32'd0);
    step();
    set_instr(32'h00005020, 5'd10, 1, 0, 0, 0, 32'd0);
    #1 check_val("lu_zero_stall", stall_ifid, 0);
    step();
    check_val("lu_zero_cnt", stall_cnt, 1);

    // dmem wait for 3 cycles, decode add $11,$9,$10
    set_instr(32'h012A5820, 5'd11, 1, 0, 0, 0, 32'd99);
    exmem_memreq = 1'b1; dhit = 1'b0;
    #1 check_val("dm_stall", stall_ifid, 1);
    for (int i = 0; i < 3; i++) step();
    check_val("dm_hold_wsel", wsel_ex, 10);
    check_val("dm_hold_rdat1", rdat1_ex, 0);
    check_val("dm_cnt", stall_cnt, 4);
    dhit = 1'b1;
    #1 check_val("dm_release_stall", stall_ifid, 0);
    step();
    check_val("dm_adv_wsel", wsel_ex, 11);
    check_val("dm_adv_rdat1", rdat1_ex, 99);
    check_val("dm_adv_cnt", stall_cnt, 4);
    exmem_memreq = 1'b0; dhit = 1'b0;

    // flush squashes sw $10,0($8)
    set_instr(32'hAD0A0000, 5'd0, 0, 0, 1, 0, 32'd1);
    flush = 1'b1;
    step();
    check_val("fl_dwen", dwen_ex, 0);
    check_val("fl_valid", valid_ex, 0);
    check_val("fl_cnt", stall_cnt, 4);
    flush = 1'b0;

    // flush and load-use in the same cycle: one bubble, IF/ID held
    set_instr(32'h8C880000, 5'd8, 1, 1, 0, 0, 32'd3);
    step();
    set_instr(32'h01095020, 5'd10, 1, 0, 0, 0, 32'd5);
    flush = 1'b1;
    #1 check_val("fllu_stall", stall_ifid, 1);
    step();
    check_val("fllu_valid", valid_ex, 0);
    check_val("fllu_cnt", stall_cnt, 5);
    flush = 1'b0;
    step();
    check_val("fllu_load_valid", valid_ex, 1);
    check_val("fllu_load_wsel", wsel_ex, 10);

    // no ihit: hold
    ihit = 1'b0;
    step();
    check_val("noihit_wsel", wsel_ex, 10);
    check_val("noihit_cnt", stall_cnt, 6);
    ihit = 1'b1;

    // halt
    set_instr(32'hFC000000, 5'd0, 0, 0, 0, 1, 32'd0);
    step();
    check_val("h_halted", halted, 1);
    check_val("h_halt_ex", halt_ex, 1);
    check_val("h_valid", valid_ex, 1);
    check_val("h_stall", stall_ifid, 1);
    set_instr(32'h01095020, 5'd10, 1, 0, 0, 0, 32'd5);
    for (int i = 0; i < 3; i++) step();
    check_val("h_post_valid", valid_ex, 0);
    check_val("h_post_halt_ex", halt_ex, 0);
    check_val("h_post_wsel", wsel_ex, 0);
    check_val("h_post_halted", halted, 1);
    check_val("h_cnt_frozen", stall_cnt, 6);
    check_val("h4_cnt_frozen", q4_stall_cnt, 6);

    // reset pulse while halted
    nRST = 1'b0;
    #1;
    check_val("hr_halted", halted, 0);
    check_val("hr_valid", valid_ex, 0);
    check_val("hr_cnt", stall_cnt, 0);
    check_val("hr_rdat2", rdat2_ex, 0);
    nRST = 1'b1;
    step();
    check_val("hr_load_valid", valid_ex, 1);
    check_val("hr_load_wsel", wsel_ex, 10);
    check_val("hr_load_halted", halted, 0);

    // saturation: 20 stalled cycles
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_val("sat16_cnt", stall_cnt, 20);
    check_val("sat4_cnt", q4_stall_cnt, 15);
    for (int i = 0; i < 2; i++) step();
    check_val("sat4_hold", q4_stall_cnt, 15);
    check_val("sat16_cnt2", stall_cnt, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
